flag_pc_unit: RTL and testbench
===============================

FLAG_PC_UNIT -- requirements
Module: flag_pc_unit

Interface
- REQ-001 The block SHALL have a parameter PC_W, default 10: program-counter width in bits.
- REQ-002 The block SHALL have a parameter START_ADDR, default 0: PC value loaded on every start.
- REQ-003 The block SHALL have input clk, 1 bit: the single clock; all state updates on its rising edge.
- REQ-004 The block SHALL have input reset_n, 1 bit: reset, asynchronous and active-low.
- REQ-005 The block SHALL have input start, 1 bit: begin execution from IDLE or HALT.
- REQ-006 The block SHALL have input stall, 1 bit: freeze all state for the current cycle.
- REQ-007 The block SHALL have input halt_req, 1 bit: the current instruction is a halt.
- REQ-008 The block SHALL have input flag_we, 1 bit: capture the ALU flags this cycle.
- REQ-009 The block SHALL have inputs sc_i, zero_i and pari_i, 1 bit each: ALU carry, zero and parity outputs.
- REQ-010 The block SHALL have input br_en, 1 bit: the current instruction is a branch.
- REQ-011 The block SHALL have input br_cond, 2 bits: 00 always, 01 zero set, 10 zero clear, 11 carry set.
- REQ-012 The block SHALL have input br_rel, 1 bit: 1 relative, 0 absolute.
- REQ-013 The block SHALL have input br_target, PC_W bits: absolute address or two's-complement offset.
- REQ-014 The block SHALL have output pc_o, PC_W bits: current instruction address.
- REQ-015 The block SHALL have outputs carry_o, zero_o and pari_o, 1 bit each: registered flags; carry_o drives the ALU sc_i.
- REQ-016 The block SHALL have output taken_o, 1 bit: registered; high for one cycle after a taken branch.
- REQ-017 The block SHALL have output done_o, 1 bit: high while in HALT.

Function
- REQ-018 The FSM SHALL have states IDLE, RUN and HALT.
- REQ-019 In IDLE with start=1, the block SHALL load pc_o=START_ADDR and enter RUN on the next edge.
- REQ-020 In HALT with start=1, the block SHALL load pc_o=START_ADDR, clear done_o and enter RUN.
- REQ-021 In RUN, start SHALL be ignored.
- REQ-022 In RUN with stall=1, pc_o, flags, state and taken_o SHALL hold; flag_we, br_en and halt_req SHALL be ignored.
- REQ-023 In RUN with stall=0, next-PC priority SHALL be: halt_req, then taken branch, then increment.
- REQ-024 On halt_req=1, the block SHALL enter HALT with pc_o held and done_o=1 from the next cycle.
- REQ-025 A branch SHALL be taken when br_en=1 and br_cond is satisfied by the flags.
- REQ-026 A taken absolute branch SHALL set pc_o=br_target.
- REQ-027 A taken relative branch SHALL set pc_o=(pc_o+br_target) mod 2^PC_W, with br_target read as signed.
- REQ-028 With no halt and no taken branch, pc_o SHALL become (pc_o+1) mod 2^PC_W; 2^PC_W-1 wraps to 0.
- REQ-029 When flag_we=1 and stall=0 in RUN, carry_o, zero_o and pari_o SHALL load sc_i, zero_i and pari_i.
- REQ-030 Flags SHALL otherwise hold, including across HALT and start.
- REQ-031 taken_o SHALL be 1 in the cycle after a taken branch and 0 otherwise.
- REQ-032 In IDLE and HALT, flag_we, br_en and halt_req SHALL be ignored.
- REQ-033 A branch and halt_req in the same cycle SHALL halt; the branch SHALL not be taken and taken_o SHALL stay 0.

Reset
- REQ-034 reset_n=0 SHALL immediately force state IDLE, pc_o=0, flags=0, taken_o=0 and done_o=0, regardless of clk.
- REQ-035 Reset asserted mid-RUN or mid-HALT SHALL discard all state, with no completion of the current instruction.
- REQ-036 The first state update after reset_n rises SHALL occur on the next clk rising edge.

Configuration
- REQ-037 With macro FLAG_BYPASS_EN defined, a branch in a cycle with flag_we=1 SHALL evaluate br_cond on sc_i and zero_i.
- REQ-038 With FLAG_BYPASS_EN undefined, branch conditions SHALL always use the registered flags, i.e. the values before this cycle's write.

Verification
- REQ-039 The bench SHALL cover reset and start: reset_n=0, then start with START_ADDR=0x020 -> pc_o 0x020, 0x021, 0x022 in consecutive RUN cycles.
- REQ-040 The bench SHALL cover wrap: pc_o=0x3FF with no branch -> pc_o=0x000 next cycle.
- REQ-041 The bench SHALL cover a relative branch: cmp writes zero_i=1, then br_cond=01, br_rel=1, br_target=0x3FC at pc_o=0x010 -> pc_o=0x00C and taken_o=1 for one cycle.
- REQ-042 The bench SHALL cover bypass: flag_we=1, zero_i=1 and br_cond=01 in the same cycle with registered zero=0 -> taken with FLAG_BYPASS_EN defined, not taken without it.
- REQ-043 The bench SHALL cover stall and halt: stall=1 for 3 cycles with br_en=1 -> pc_o and flags unchanged; then halt_req=1 with br_en=1 -> done_o=1, pc_o held, taken_o=0.
- REQ-044 The bench SHALL cover async reset mid-RUN at pc_o=0x155: reset_n=0 between edges -> pc_o=0 and state IDLE before the next edge.

Source files
------------

// File: rtl/flag_pc_unit.sv
// Program counter with ALU flag register and branch resolution.
// Define FLAG_BYPASS_EN to resolve branches on same-cycle ALU flags.
module flag_pc_unit #(
  parameter int          PC_W       = 10,
  parameter int unsigned START_ADDR = 0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            stall,
  input  logic            halt_req,
  input  logic            flag_we,
  input  logic            sc_i,
  input  logic            zero_i,
  input  logic            pari_i,
  input  logic            br_en,
  input  logic [1:0]      br_cond,
  input  logic            br_rel,
  input  logic [PC_W-1:0] br_target,
  output logic [PC_W-1:0] pc_o,
  output logic            carry_o,
  output logic            zero_o,
  output logic            pari_o,
  output logic            taken_o,
  output logic            done_o
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            c_q, c_d;
  logic            z_q, z_d;
  logic            p_q, p_d;
  logic            tk_q, tk_d;
  logic            c_eff, z_eff;
  logic            cond_ok;

`ifdef FLAG_BYPASS_EN
  assign c_eff = flag_we ? sc_i   : c_q;
  assign z_eff = flag_we ? zero_i : z_q;
`else
  assign c_eff = c_q;
  assign z_eff = z_q;
`endif

  always_comb begin
    cond_ok = 1'b0;
    unique case (br_cond)
      2'b00: cond_ok = 1'b1;
      2'b01: cond_ok = z_eff;
      2'b10: cond_ok = ~z_eff;
      2'b11: cond_ok = c_eff;
      default: cond_ok = 1'b0;
    endcase
  end

  // stall freezes everything, including taken_o
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    c_d     = c_q;
    z_d     = z_q;
    p_d     = p_q;
    tk_d    = tk_q;
    if (!stall) begin
      tk_d = 1'b0;
      unique case (state_q)
        IDLE, HALT: begin
          if (start) begin
            pc_d    = PC_W'(START_ADDR);
            state_d = RUN;
          end
        end
        RUN: begin
          if (flag_we) begin
            c_d = sc_i;
            z_d = zero_i;
            p_d = pari_i;
          end
          if (halt_req) begin
            state_d = HALT;
          end else if (br_en && cond_ok) begin
            pc_d = br_rel ? pc_q + br_target
                          : br_target;
            tk_d = 1'b1;
          end else begin
            pc_d = pc_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      p_q     <= 1'b0;
      tk_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      c_q     <= c_d;
      z_q     <= z_d;
      p_q     <= p_d;
      tk_q    <= tk_d;
    end
  end

  assign pc_o    = pc_q;
  assign carry_o = c_q;
  assign zero_o  = z_q;
  assign pari_o  = p_q;
  assign taken_o = tk_q;
  assign done_o  = (state_q == HALT);

endmodule

// File: tb/tb_flag_pc_unit.sv
// Directed bench for flag_pc_unit: start, branches, wrap,
// flag bypass, stall, halt and asynchronous reset.
`timescale 1ns/1ps
module tb_flag_pc_unit;

  localparam int PC_W = 10;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            start, stall, halt_req, flag_we;
  logic            sc_i, zero_i, pari_i;
  logic            br_en, br_rel;
  logic [1:0]      br_cond;
  logic [PC_W-1:0] br_target;
  logic [PC_W-1:0] pc_o;
  logic            carry_o, zero_o, pari_o;
  logic            taken_o, done_o;

  int passed = 0;
  int total  = 0;

  flag_pc_unit #(
    .PC_W      (PC_W),
    .START_ADDR(32'h020)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .stall    (stall),
    .halt_req (halt_req),
    .flag_we  (flag_we),
    .sc_i     (sc_i),
    .zero_i   (zero_i),
    .pari_i   (pari_i),
    .br_en    (br_en),
    .br_cond  (br_cond),
    .br_rel   (br_rel),
    .br_target(br_target),
    .pc_o     (pc_o),
    .carry_o  (carry_o),
    .zero_o   (zero_o),
    .pari_o   (pari_o),
    .taken_o  (taken_o),
    .done_o   (done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic br(input logic [1:0] c,
                    input logic r,
                    input logic [PC_W-1:0] t);
    br_en     = 1'b1;
    br_cond   = c;
    br_rel    = r;
    br_target = t;
  endtask

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    stall     = 1'b0;
    halt_req  = 1'b0;
    flag_we   = 1'b0;
    sc_i      = 1'b0;
    zero_i    = 1'b0;
    pari_i    = 1'b0;
    br_en     = 1'b0;
    br_cond   = 2'b00;
    br_rel    = 1'b0;
    br_target = '0;

    #3;
    chk("rst_pc", pc_o, 0);
    chk("rst_flags", {carry_o, zero_o, pari_o}, 0);
    chk("rst_taken", taken_o, 0);
    chk("rst_done", done_o, 0);
    #9 reset_n = 1'b1;

    tick();
    chk("idle_pc", pc_o, 0);
    chk("idle_done", done_o, 0);

    start = 1'b1;
    tick();
    chk("start_pc0", pc_o, 10'h020);
    tick();
    chk("start_ign_pc1", pc_o, 10'h021);
    start = 1'b0;
    tick();
    chk("run_pc2", pc_o, 10'h022);
    chk("run_flags", {carry_o, zero_o, pari_o}, 0);

    br(2'b00, 1'b0, 10'h00F);
    tick();
    chk("abs_pc", pc_o, 10'h00F);
    chk("abs_taken", taken_o, 1);

    br_en   = 1'b0;
    flag_we = 1'b1;
    zero_i  = 1'b1;
    pari_i  = 1'b1;
    tick();
    chk("cmp_pc", pc_o, 10'h010);
    chk("cmp_taken", taken_o, 0);
    chk("cmp_flags", {carry_o, zero_o, pari_o}, 3'b011);

    flag_we = 1'b0;
    br(2'b01, 1'b1, 10'h3FC);
    tick();
    chk("rel_pc", pc_o, 10'h00C);
    chk("rel_taken", taken_o, 1);
    br_en = 1'b0;
    tick();
    chk("rel_next_pc", pc_o, 10'h00D);
    chk("rel_taken_drop", taken_o, 0);

    br(2'b10, 1'b0, 10'h100);
    tick();
    chk("nz_nt_pc", pc_o, 10'h00E);
    chk("nz_nt_taken", taken_o, 0);
    br(2'b11, 1'b0, 10'h100);
    tick();
    chk("c_nt_pc", pc_o, 10'h00F);

    br(2'b00, 1'b0, 10'h3FF);
    tick();
    chk("to_3ff", pc_o, 10'h3FF);
    br_en = 1'b0;
    tick();
    chk("wrap_pc", pc_o, 10'h000);

    flag_we = 1'b1;
    sc_i    = 1'b1;
    zero_i  = 1'b0;
    pari_i  = 1'b0;
    tick();
    chk("clrz_flags", {carry_o, zero_o, pari_o}, 3'b100);
    chk("clrz_pc", pc_o, 10'h001);

    sc_i   = 1'b0;
    zero_i = 1'b1;
    br(2'b01, 1'b0, 10'h200);
    tick();
`ifdef FLAG_BYPASS_EN
    chk("byp_pc", pc_o, 10'h200);
    chk("byp_taken", taken_o, 1);
`else
    chk("byp_pc", pc_o, 10'h002);
    chk("byp_taken", taken_o, 0);
`endif
    chk("byp_flags", {carry_o, zero_o, pari_o}, 3'b010);

    flag_we = 1'b0;
    br(2'b00, 1'b0, 10'h080);
    tick();
    br_en = 1'b0;
    tick();
    chk("pre_stall_pc", pc_o, 10'h081);

    stall   = 1'b1;
    flag_we = 1'b1;
    sc_i    = 1'b1;
    zero_i  = 1'b0;
    pari_i  = 1'b1;
    br(2'b00, 1'b0, 10'h300);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", pc_o, 10'h081);
      chk("stall_flags",
          {carry_o, zero_o, pari_o}, 3'b010);
      chk("stall_taken", taken_o, 0);
    end

    stall    = 1'b0;
    flag_we  = 1'b0;
    halt_req = 1'b1;
    tick();
    chk("halt_done", done_o, 1);
    chk("halt_pc", pc_o, 10'h081);
    chk("halt_taken", taken_o, 0);
    halt_req = 1'b0;
    flag_we  = 1'b1;
    tick();
    chk("halt_hold_pc", pc_o, 10'h081);
    chk("halt_hold_flags",
        {carry_o, zero_o, pari_o}, 3'b010);

    flag_we = 1'b0;
    br_en   = 1'b0;
    start   = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_pc", pc_o, 10'h020);
    chk("restart_done", done_o, 0);
    chk("restart_flags",
        {carry_o, zero_o, pari_o}, 3'b010);

    br(2'b00, 1'b0, 10'h154);
    tick();
    br_en = 1'b0;
    tick();
    chk("pre_rst_pc", pc_o, 10'h155);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_pc", pc_o, 0);
    chk("arst_flags", {carry_o, zero_o, pari_o}, 0);
    chk("arst_done", done_o, 0);
    #2 reset_n = 1'b1;
    tick();
    chk("arst_idle_pc", pc_o, 0);
    tick();
    chk("arst_idle_pc2", pc_o, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
